prim_rr_arb: RTL

//  N-requester round-robin arbiter in front of a shared prim_fifo2 output stage.

---
 rtl/prim_rr_arb_pkg.sv | 15 +
 rtl/prim_fifo2.sv | 50 +++++
 rtl/prim_rr_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/prim_rr_arb_pkg.sv
// Shared types and helpers for the prim_rr_arb round-robin arbiter.
package prim_rr_arb_pkg;

    // Packet-lock state of the arbiter (only used when packet locking is built in).
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a requester id tag; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prim_fifo2.sv
// Two-entry ready/valid buffer with a downstream stall.
// Upstream ready depends only on the fill level, so there is no combinational
// path from the downstream handshake back to the producer.
module prim_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wvld,
    input  logic [WIDTH-1:0] wdat,
    output logic             wrdy,
    input  logic             stall,
    input  logic             rrdy,
    output logic             rvld,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    // Outputs are forced idle during reset so no beat completes in a reset cycle.
    assign wrdy = reset && (cnt != 2'd2);
    assign rvld = reset && (cnt != 2'd0) && !stall;
    assign rdat = mem[rd_ptr];
    assign push = wvld && wrdy;
    assign pop  = rvld && rrdy;

    // Occupancy and pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    // Storage; a held head entry is never overwritten because the write slot differs.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

endmodule

// File: rtl/prim_rr_arb.sv
// N-requester round-robin arbiter feeding a shared two-entry output buffer.
// Each accepted beat is tagged with its requester id.
// Optional feature macro PRIM_RR_ARB_LOCK_EN: adds ulast_i and holds the grant
// on one requester until it sends a beat with ulast_i set.
module prim_rr_arb
    import prim_rr_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned IDW   = id_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       uvld_i,
    input  logic [N*WIDTH-1:0] udat_i,
`ifdef PRIM_RR_ARB_LOCK_EN
    input  logic [N-1:0]       ulast_i,
`endif
    output logic [N-1:0]       urdy_o,
    input  logic               dstall_i,
    input  logic               drdy_i,
    output logic               dvld_o,
    output logic [WIDTH-1:0]   ddat_o,
    output logic [IDW-1:0]     did_o
);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } arb_beat_t;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] scan_grant;
    logic           scan_vld;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    logic           beat_last;
    logic           fifo_wrdy;
    logic           ubeat;
    arb_beat_t      wbeat;
    arb_beat_t      rbeat;

    // Requester index at offset off from base, modulo N (base and off are both < N).
    function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base,
                                               input int unsigned  off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    // Rotating-priority scan: first valid requester starting at ptr.
    always_comb begin
        scan_grant = '0;
        scan_vld   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!scan_vld && uvld_i[rot_idx(ptr, k)]) begin
                scan_vld   = 1'b1;
                scan_grant = rot_idx(ptr, k);
            end
        end
    end

`ifdef PRIM_RR_ARB_LOCK_EN
    arb_state_e     state;
    arb_state_e     state_next;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] lock_id_next;

    // Lock state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ARB_FREE;
            lock_id <= '0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
        end
    end

    // Grant select: a locked requester is the only candidate, valid or not.
    always_comb begin
        grant     = scan_grant;
        grant_vld = scan_vld;
        if (state == ARB_LOCKED) begin
            grant     = lock_id;
            grant_vld = uvld_i[lock_id];
        end
        beat_last = ulast_i[grant];
    end

    // Lock next-state: a non-last beat locks onto its source, a last beat frees.
    always_comb begin
        state_next   = state;
        lock_id_next = lock_id;
        if (ubeat) begin
            if (beat_last) begin
                state_next = ARB_FREE;
            end else begin
                state_next   = ARB_LOCKED;
                lock_id_next = grant;
            end
        end
    end
`else
    assign grant     = scan_grant;
    assign grant_vld = scan_vld;
    assign beat_last = 1'b1;
`endif

    assign ubeat = grant_vld && fifo_wrdy;

    // Only the granted requester sees ready.
    always_comb begin
        urdy_o        = '0;
        urdy_o[grant] = ubeat;
    end

    // Round-robin pointer moves past the winner on every completed beat (packet).
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (ubeat && beat_last) begin
            ptr <= (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign wbeat.id   = grant;
    assign wbeat.data = udat_i[32'(grant)*WIDTH +: WIDTH];

    prim_fifo2 #(
        .WIDTH(IDW + WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wvld  (grant_vld),
        .wdat  (wbeat),
        .wrdy  (fifo_wrdy),
        .stall (dstall_i),
        .rrdy  (drdy_i),
        .rvld  (dvld_o),
        .rdat  (rbeat)
    );

    assign ddat_o = rbeat.data;
    assign did_o  = rbeat.id;

endmodule
